// File: rtl/rvc_asap_pkg.sv
// Shared types and helpers for the rvc_asap memory wrapper: loader FSM states,
// access-width codes and the load result extender.
package rvc_asap_pkg;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_RUN  = 2'd1,
      LD_DONE = 2'd2
   } t_ld_state;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Fill the bytes above the access width with the top enabled bit or zero.
   function automatic logic [31:0] load_extend(input logic [31:0] data,
                                               input logic [3:0]  byte_en,
                                               input logic        sign_ext);
      logic [31:0] r_res;
      case (byte_en)
         BE_BYTE: r_res = {{24{sign_ext & data[7]}}, data[7:0]};
         BE_HALF: r_res = {{16{sign_ext & data[15]}}, data[15:0]};
         default: r_res = data;
      endcase
      return r_res;
   endfunction

endpackage

// File: rtl/rvc_mem_ldr.sv
// I_MEM loader: accepts a valid/ready word stream after a start pulse and
// turns it into a word-wide I_MEM write port. Current state is exposed on o_state.
module rvc_mem_ldr
   import rvc_asap_pkg::*;
#(
   parameter int I_MEM_BYTES = 4096,
   localparam int WORDS = I_MEM_BYTES / 4,
   localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_valid,
   input  logic [31:0]   i_data,
   input  logic          i_last,
   output t_ld_state     o_state,
   output logic          o_we,
   output logic [CW-1:0] o_waddr,
   output logic [31:0]   o_wdata
);

   localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

   // Handshake: a word transfers on a rising edge where valid is high and the
   // FSM is in LD_RUN (ready); the data is written to I_MEM on that same edge.
   t_ld_state     r_state;
   t_ld_state     w_next;
   logic [CW-1:0] r_cnt;
   logic          w_xfer;
   logic          w_at_end;

   assign w_xfer   = (r_state == LD_RUN) && i_valid;
   assign w_at_end = (r_cnt == LAST_WORD);

   always_comb begin
      w_next = r_state;
      case (r_state)
         LD_IDLE: if (i_start) w_next = LD_RUN;
         LD_RUN:  if (w_xfer && (i_last || w_at_end)) w_next = LD_DONE;
         LD_DONE: w_next = LD_IDLE;
         default: w_next = LD_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= LD_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == LD_IDLE) && i_start) begin
            r_cnt <= '0;
         end else if (w_xfer && !w_at_end) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // A word presented in the same cycle as reset is dropped, so a reset
   // mid-load leaves only the words that completed before it.
   assign o_we    = w_xfer && i_rst_n;
   assign o_waddr = r_cnt;
   assign o_wdata = i_data;
   assign o_state = r_state;

endmodule

// File: rtl/rvc_mem_wrap_pipe.sv
// Memory wrapper for the pipelined rvc_asap core: registered-read I_MEM fetch
// port, byte-enabled D_MEM load/store port with checking, and a stream loader.
module rvc_mem_wrap_pipe
   import rvc_asap_pkg::*;
#(
   parameter int I_MEM_BYTES = 4096,
   parameter int D_MEM_BASE  = 4096,
   parameter int D_MEM_BYTES = 4096
) (
   input  logic        Clock,
   input  logic        Rst,
   input  logic [31:0] Pc,
   input  logic        FetchEn,
   output logic [31:0] Instruction,
   output logic        InstrValid,
   output logic        FetchFault,
   input  logic [31:0] DMemAddr,
   input  logic [31:0] DMemWrData,
   input  logic [3:0]  DMemByteEn,
   input  logic        DMemWrEn,
   input  logic        DMemRdEn,
   input  logic        CtrlSignExt,
   output logic [31:0] DMemRdData,
   output logic        DMemRdValid,
   output logic        DMemErr,
   input  logic        LdStart,
   input  logic        LdValid,
   input  logic [31:0] LdData,
   input  logic        LdLast,
   output logic        LdReady,
   output logic        LdBusy
);

   localparam int IWORDS = I_MEM_BYTES / 4;
   localparam int CW     = (IWORDS > 1) ? $clog2(IWORDS) : 1;
   localparam int DW     = $clog2(D_MEM_BYTES);

   localparam logic [31:0] DBASE = 32'(D_MEM_BASE);
   localparam logic [32:0] D_LO  = 33'(D_MEM_BASE);
   localparam logic [32:0] D_HI  = 33'(D_MEM_BASE) + 33'(D_MEM_BYTES);

   // ---------------- loader ----------------
   t_ld_state     w_ld_state;
   logic          w_ld_we;
   logic [CW-1:0] w_ld_waddr;
   logic [31:0]   w_ld_wdata;
   logic          w_ld_busy;

   rvc_mem_ldr #(
      .I_MEM_BYTES (I_MEM_BYTES)
   ) u_ldr (
      .i_clk   (Clock),
      .i_rst_n (Rst),
      .i_start (LdStart),
      .i_valid (LdValid),
      .i_data  (LdData),
      .i_last  (LdLast),
      .o_state (w_ld_state),
      .o_we    (w_ld_we),
      .o_waddr (w_ld_waddr),
      .o_wdata (w_ld_wdata)
   );

   assign w_ld_busy = (w_ld_state != LD_IDLE);
   assign LdBusy    = w_ld_busy;
   assign LdReady   = (w_ld_state == LD_RUN);

   // ---------------- I_MEM ----------------
   // Kept word-wide: the loader only writes whole words and fetches must be
   // word aligned, so byte lanes never need to be addressed separately.
   logic [31:0]   r_imem [IWORDS];
   logic          w_fetch;
   logic          w_fetch_bad;
   logic [CW-1:0] w_fidx;
   logic [31:0]   r_instr;
   logic          r_ivalid;
   logic          r_ffault;

   assign w_fetch     = FetchEn && !w_ld_busy;
   assign w_fetch_bad = (Pc >= 32'(I_MEM_BYTES)) || (Pc[1:0] != 2'b00);
   assign w_fidx      = CW'(Pc[31:2]);

   always_ff @(posedge Clock) begin
      if (w_ld_we) begin
         r_imem[w_ld_waddr] <= w_ld_wdata;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Rst) begin
         r_instr  <= '0;
         r_ivalid <= 1'b0;
         r_ffault <= 1'b0;
      end else begin
         r_ivalid <= w_fetch;
         r_ffault <= w_fetch && w_fetch_bad;
         if (w_fetch) begin
            r_instr <= w_fetch_bad ? 32'h0 : r_imem[w_fidx];
         end
      end
   end

   assign Instruction = r_instr;
   assign InstrValid  = r_ivalid;
   assign FetchFault  = r_ffault;

   // ---------------- D_MEM ----------------
   logic [7:0]    r_dmem [D_MEM_BYTES];
   logic [32:0]   w_width;
   logic          w_be_ok;
   logic          w_aligned;
   logic          w_in_range;
   logic          w_legal;
   logic [DW-1:0] w_idx0;
   logic [31:0]   w_raw;
   logic          w_store;
   logic          w_load;
   logic [31:0]   r_rdata;
   logic          r_rvalid;
   logic          r_err;

   always_comb begin
      w_width   = 33'd0;
      w_be_ok   = 1'b1;
      w_aligned = 1'b1;
      case (DMemByteEn)
         BE_BYTE: w_width = 33'd1;
         BE_HALF: begin
            w_width   = 33'd2;
            w_aligned = ~DMemAddr[0];
         end
         BE_WORD: begin
            w_width   = 33'd4;
            w_aligned = (DMemAddr[1:0] == 2'b00);
         end
         default: w_be_ok = 1'b0;
      endcase
   end

   // 33-bit compare so a window ending at 2^32 and Addr near the top both work.
   assign w_in_range = ({1'b0, DMemAddr} >= D_LO) &&
                       (({1'b0, DMemAddr} + w_width - 33'd1) < D_HI);
   assign w_legal    = w_be_ok && w_aligned && w_in_range;
   assign w_idx0     = DMemAddr[DW-1:0] - DBASE[DW-1:0];
   assign w_store    = Rst && DMemWrEn && w_legal;
   assign w_load     = DMemRdEn && !DMemWrEn;

   always_comb begin
      w_raw = '0;
      for (int k = 0; k < 4; k++) begin
         w_raw[8*k +: 8] = r_dmem[w_idx0 + DW'(k)];
      end
   end

   always_ff @(posedge Clock) begin
      for (int k = 0; k < 4; k++) begin
         if (w_store && DMemByteEn[k]) begin
            r_dmem[w_idx0 + DW'(k)] <= DMemWrData[8*k +: 8];
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Rst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= w_load;
         r_err    <= (DMemWrEn || DMemRdEn) && !w_legal;
         if (w_load) begin
            r_rdata <= w_legal ? load_extend(w_raw, DMemByteEn, CtrlSignExt) : 32'h0;
         end
      end
   end

   assign DMemRdData  = r_rdata;
   assign DMemRdValid = r_rvalid;
   assign DMemErr     = r_err;

endmodule
